// File: rtl/triumph_wb_stage.sv
// -----------------------------------------------------------------------------
// triumph_wb_stage
//
// Writeback stage of the Triumph pipeline. It accepts one retired instruction
// per handshake and drives the register-file write port with a single
// registered pulse per instruction. For a load it waits for the data-memory
// response, then aligns and sign- or zero-extends the returned data. It flags
// misaligned loads, bus errors and response timeouts as one-cycle pulses.
//
// Parameters
//   LOAD_TIMEOUT       cycles allowed in WAIT_LOAD before a timeout error
//                      (legal range 2..255)
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   ex_valid_i         instruction presented by EX/MEM
//   ex_ready_o         stage can accept (high only in IDLE)
//   ex_rd_addr_i       destination register
//   ex_rd_we_i         instruction writes rd
//   ex_alu_result_i    rd data for non-loads
//   ex_is_load_i       instruction is a load
//   ex_load_size_i     00 byte, 01 half, 10 word, 11 reserved (word)
//   ex_load_unsigned_i zero-extend when set, sign-extend when clear
//   ex_addr_lsb_i      load address bits [1:0]
//   dmem_rvalid_i      data-memory response valid
//   dmem_rdata_i       data-memory read word
//   dmem_err_i         bus error, qualified by dmem_rvalid_i
//   data_valid_wb_o    register-file write enable pulse
//   rd_addr_wb_o       register-file write address (held between writes)
//   rd_data_wb_o       register-file write data (held between writes)
//   load_err_o         bus error or timeout pulse
//   misalign_err_o     misaligned load pulse
// -----------------------------------------------------------------------------
module triumph_wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_we_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic        ex_is_load_i,
  input  logic [1:0]  ex_load_size_i,
  input  logic        ex_load_unsigned_i,
  input  logic [1:0]  ex_addr_lsb_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        data_valid_wb_o,
  output logic [4:0]  rd_addr_wb_o,
  output logic [31:0] rd_data_wb_o,
  output logic        load_err_o,
  output logic        misalign_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } state_e;

  // The counter reads 0 in the first WAIT_LOAD cycle, so a timeout fires when
  // it is about to step to LOAD_TIMEOUT-1; the error pulse then lands exactly
  // LOAD_TIMEOUT cycles after the accept.
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 32'd2);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Misaligned: half with odd address, word/reserved with any nonzero lsb.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lsb);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lsb[0];
      default:   mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [1:0]  lsb);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (lsb)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: res = uns ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      SIZE_HALF: res = uns ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
      default:   res = rdata;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_we_q, ld_we_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  ld_lsb_q, ld_lsb_d;
  logic        valid_q, valid_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        load_err_q, load_err_d;
  logic        misalign_q, misalign_d;

  // Next-state and registered-output computation for the writeback FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    ld_lsb_d   = ld_lsb_q;
    valid_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    load_err_d = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          if (!ex_is_load_i) begin
            // Address/data only move on a real write so they hold otherwise.
            if (ex_rd_we_i && (ex_rd_addr_i != 5'd0)) begin
              valid_d   = 1'b1;
              rd_addr_d = ex_rd_addr_i;
              rd_data_d = ex_alu_result_i;
            end else begin
              valid_d   = 1'b0;
            end
          end else if (is_misaligned(ex_load_size_i, ex_addr_lsb_i)) begin
            misalign_d = 1'b1;
          end else begin
            ld_rd_d   = ex_rd_addr_i;
            ld_we_d   = ex_rd_we_i;
            ld_size_d = ex_load_size_i;
            ld_uns_d  = ex_load_unsigned_i;
            ld_lsb_d  = ex_addr_lsb_i;
            cnt_d     = 8'd0;
            state_d   = ST_WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_LOAD: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the final allowed cycle beats the timeout.
        if (dmem_rvalid_i) begin
          state_d = ST_IDLE;
          if (dmem_err_i) begin
            load_err_d = 1'b1;
          end else if (ld_we_q && (ld_rd_q != 5'd0)) begin
            valid_d   = 1'b1;
            rd_addr_d = ld_rd_q;
            rd_data_d = align_load(dmem_rdata_i, ld_size_q, ld_uns_q, ld_lsb_q);
          end else begin
            valid_d   = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          load_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, load context and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      ld_rd_q    <= 5'd0;
      ld_we_q    <= 1'b0;
      ld_size_q  <= 2'b00;
      ld_uns_q   <= 1'b0;
      ld_lsb_q   <= 2'b00;
      valid_q    <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= 32'h0000_0000;
      load_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_size_q  <= ld_size_d;
      ld_uns_q   <= ld_uns_d;
      ld_lsb_q   <= ld_lsb_d;
      valid_q    <= valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      load_err_q <= load_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign ex_ready_o      = (state_q == ST_IDLE);
  assign data_valid_wb_o = valid_q;
  assign rd_addr_wb_o    = rd_addr_q;
  assign rd_data_wb_o    = rd_data_q;
  assign load_err_o      = load_err_q;
  assign misalign_err_o  = misalign_q;

endmodule

// File: tb/tb_triumph_wb_stage.sv
module tb_triumph_wb_stage;

  localparam int T = 4;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_LERR = 2'd1;
  localparam logic [1:0] K_MIS  = 2'd2;
  localparam logic [1:0] K_NONE = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd_addr = 5'd0;
  logic        ex_rd_we = 1'b0;
  logic [31:0] ex_alu = 32'h0;
  logic        ex_is_load = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_uns = 1'b0;
  logic [1:0]  ex_lsb = 2'b00;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        derr = 1'b0;
  logic        dv;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lerr;
  logic        merr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  triumph_wb_stage #(.LOAD_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_rd_addr_i(ex_rd_addr), .ex_rd_we_i(ex_rd_we),
    .ex_alu_result_i(ex_alu), .ex_is_load_i(ex_is_load),
    .ex_load_size_i(ex_size), .ex_load_unsigned_i(ex_uns),
    .ex_addr_lsb_i(ex_lsb),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .dmem_err_i(derr),
    .data_valid_wb_o(dv), .rd_addr_wb_o(wb_addr), .rd_data_wb_o(wb_data),
    .load_err_o(lerr), .misalign_err_o(merr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [4:0] addr,
                      input logic [31:0] data, input int at);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents any output pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [1:0] k;
    int nh;
    if (!rst_i) begin
      nh = int'(dv) + int'(lerr) + int'(merr);
      checks++;
      if (nh > 1) begin
        errors++;
        $display("FAIL onehot actual=%0d%0d%0d expected at most one (cycle %0d)", dv, lerr, merr, cyc);
      end
      if (nh != 0) begin
        k = dv ? K_WR : (lerr ? K_LERR : K_MIS);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual kind=%0d addr=%0d data=%h expected none (cycle %0d)", k, wb_addr, wb_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (k !== e.kind || cyc != e.cyc) begin
            errors++;
            $display("FAIL pulse actual kind=%0d cycle=%0d expected kind=%0d cycle=%0d", k, cyc, e.kind, e.cyc);
          end
          if (e.kind == K_WR) begin
            checks++;
            if (wb_addr !== e.addr || wb_data !== e.data) begin
              errors++;
              $display("FAIL wb_payload actual=%0d/%h expected=%0d/%h (cycle %0d)", wb_addr, wb_data, e.addr, e.data, cyc);
            end
          end
        end
      end
    end
  end

  task automatic alu(input logic [4:0] rd, input logic we, input logic [31:0] res,
                     input logic exp_wr);
    int n;
    n = cyc;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_addr = rd; ex_rd_we = we; ex_alu = res;
    if (exp_wr) push(K_WR, rd, res, n + 1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // delay = cycles from accept to rvalid; 0 means no response (timeout).
  task automatic load(input logic [4:0] rd, input logic we, input logic [1:0] size,
                      input logic uns, input logic [1:0] lsb, input int delay,
                      input logic [31:0] rd_word, input logic err,
                      input logic [1:0] exp_kind, input logic [31:0] exp_data,
                      input logic early);
    int n;
    n = cyc;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = rd; ex_rd_we = we;
    ex_size = size; ex_uns = uns; ex_lsb = lsb;
    if (early) begin
      rvalid = 1'b1; rdata = 32'hA5A5_A5A5; derr = 1'b0;
    end
    if (exp_kind == K_MIS) begin
      push(K_MIS, 5'd0, 32'h0, n + 1);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_load = 1'b0; rvalid = 1'b0;
      chk("mis_ready", 32'(ex_ready), 32'd1);
    end else begin
      if (delay == 0) begin
        if (exp_kind != K_NONE) push(exp_kind, rd, exp_data, n + T);
      end else begin
        if (exp_kind != K_NONE) push(exp_kind, rd, exp_data, n + delay + 1);
      end
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_load = 1'b0; rvalid = 1'b0;
      if (delay == 0) begin
        for (int i = 1; i < T; i++) begin
          chk("wait_ready_low", 32'(ex_ready), 32'd0);
          @(posedge clk); #1;
        end
        chk("timeout_ready", 32'(ex_ready), 32'd1);
      end else begin
        for (int i = 1; i <= delay; i++) begin
          chk("wait_ready_low", 32'(ex_ready), 32'd0);
          if (i == delay) begin
            rvalid = 1'b1; rdata = rd_word; derr = err;
          end
          @(posedge clk); #1;
        end
        rvalid = 1'b0; derr = 1'b0;
        chk("resp_ready", 32'(ex_ready), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_addr", 32'(wb_addr), 32'd0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_lerr", 32'(lerr), 32'd0);
    chk("rst_merr", 32'(merr), 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd1);

    // ADD rd=5, then pulse must drop while values hold
    alu(5'd5, 1'b1, 32'h0000_1234, 1'b1);
    @(posedge clk); #1;
    chk("add_pulse_end", 32'(dv), 32'd0);
    chk("add_hold_addr", 32'(wb_addr), 32'd5);
    chk("add_hold_data", wb_data, 32'h0000_1234);

    // back-to-back non-loads, rd=0 and we=0 suppressed
    alu(5'd6, 1'b1, 32'h1111_1111, 1'b1);
    alu(5'd7, 1'b1, 32'h2222_2222, 1'b1);
    alu(5'd0, 1'b1, 32'h3333_3333, 1'b0);
    alu(5'd8, 1'b0, 32'h4444_4444, 1'b0);

    // loads: rd we size uns lsb delay rdata err kind expected early
    load(5'd10, 1'b1, 2'b00, 1'b0, 2'd3, 3, 32'h80FF_FF00, 1'b0, K_WR, 32'hFFFF_FF80, 1'b0);
    load(5'd11, 1'b1, 2'b00, 1'b1, 2'd3, 3, 32'h80FF_FF00, 1'b0, K_WR, 32'h0000_0080, 1'b0);
    load(5'd12, 1'b1, 2'b01, 1'b0, 2'd2, 2, 32'h7FFF_8001, 1'b0, K_WR, 32'h0000_7FFF, 1'b0);
    load(5'd13, 1'b1, 2'b01, 1'b0, 2'd0, 1, 32'h7FFF_8001, 1'b0, K_WR, 32'hFFFF_8001, 1'b1);
    load(5'd14, 1'b1, 2'b01, 1'b1, 2'd0, 1, 32'h7FFF_8001, 1'b0, K_WR, 32'h0000_8001, 1'b0);
    load(5'd15, 1'b1, 2'b00, 1'b0, 2'd1, 2, 32'h1234_5678, 1'b0, K_WR, 32'h0000_0056, 1'b0);
    load(5'd16, 1'b1, 2'b10, 1'b0, 2'd0, 1, 32'hCAFE_F00D, 1'b0, K_WR, 32'hCAFE_F00D, 1'b0);
    load(5'd17, 1'b1, 2'b11, 1'b1, 2'd0, 2, 32'h89AB_CDEF, 1'b0, K_WR, 32'h89AB_CDEF, 1'b0);

    // misaligned half, next instruction accepted immediately
    load(5'd18, 1'b1, 2'b01, 1'b0, 2'd1, 1, 32'h0, 1'b0, K_MIS, 32'h0, 1'b0);
    alu(5'd19, 1'b1, 32'h0000_5A5A, 1'b1);
    load(5'd18, 1'b1, 2'b10, 1'b0, 2'd2, 1, 32'h0, 1'b0, K_MIS, 32'h0, 1'b0);

    // suppressed writes and bus error
    load(5'd0,  1'b1, 2'b10, 1'b0, 2'd0, 2, 32'h1234_5678, 1'b0, K_NONE, 32'h0, 1'b0);
    load(5'd20, 1'b0, 2'b10, 1'b0, 2'd0, 2, 32'h1234_5678, 1'b0, K_NONE, 32'h0, 1'b0);
    load(5'd21, 1'b1, 2'b10, 1'b0, 2'd0, 2, 32'h0000_0001, 1'b1, K_LERR, 32'h0, 1'b0);

    // timeout, then a late response in IDLE is ignored
    load(5'd23, 1'b1, 2'b10, 1'b0, 2'd0, 0, 32'h0, 1'b0, K_LERR, 32'h0, 1'b0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(posedge clk); #1;
    chk("late_no_write", 32'(dv), 32'd0);
    chk("late_hold_addr", 32'(wb_addr), 32'd19);
    chk("late_hold_data", wb_data, 32'h0000_5A5A);

    // reset during WAIT_LOAD abandons the load
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd24; ex_rd_we = 1'b1;
    ex_size = 2'b10; ex_uns = 1'b0; ex_lsb = 2'd0;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("pre_rst_busy", 32'(ex_ready), 32'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("mid_rst_valid", 32'(dv), 32'd0);
    chk("mid_rst_addr", 32'(wb_addr), 32'd0);
    chk("mid_rst_data", wb_data, 32'h0);
    chk("mid_rst_lerr", 32'(lerr), 32'd0);
    chk("mid_rst_ready", 32'(ex_ready), 32'd1);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("post_rst_no_write", 32'(dv), 32'd0);
    alu(5'd25, 1'b1, 32'h0000_ABCD, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triumph_wb_stage.md
# triumph_wb_stage

Writeback stage of the Triumph pipeline. It accepts one retired instruction per handshake from the EX/MEM side, waits for the data-memory response on loads, and aligns and sign- or zero-extends load data. It drives the register file write port (valid, rd address, rd data) with a single registered pulse per instruction. It also flags misaligned loads, bus errors and response timeouts.

## Interface
Parameters:
- `LOAD_TIMEOUT`, default 16: maximum number of cycles spent in WAIT_LOAD before a timeout error is raised; legal range 2..255.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `ex_valid_i`  in  1  an instruction is presented.
- `ex_ready_o`  out  1  stage can accept; equals (state == IDLE).
- `ex_rd_addr_i`  in  5  destination register.
- `ex_rd_we_i`  in  1  instruction writes rd.
- `ex_alu_result_i`  in  32  ALU result; used as rd data for non-loads.
- `ex_is_load_i`  in  1  instruction is a load.
- `ex_load_size_i`  in  2  load size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `ex_load_unsigned_i`  in  1  zero-extend when set, sign-extend when clear.
- `ex_addr_lsb_i`  in  2  load address bits [1:0].
- `dmem_rvalid_i`  in  1  data-memory response valid.
- `dmem_rdata_i`  in  32  data-memory read word.
- `dmem_err_i`  in  1  bus error; qualified by `dmem_rvalid_i`.
- `data_valid_wb_o`  out  1  register-file write enable (one-cycle pulse).
- `rd_addr_wb_o`  out  5  register-file write address.
- `rd_data_wb_o`  out  32  register-file write data.
- `load_err_o`  out  1  one-cycle pulse: bus error or timeout.
- `misalign_err_o`  out  1  one-cycle pulse: misaligned load.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- **IDLE:** a handshake occurs when `ex_valid_i` is high (`ex_ready_o` is always high in IDLE).
  - Non-load: register `data_valid_wb_o` = `ex_rd_we_i` && (`ex_rd_addr_i` != 0), `rd_addr_wb_o` = `ex_rd_addr_i`, `rd_data_wb_o` = `ex_alu_result_i`. Stay in IDLE.
  - Misaligned load: half with lsb[0] = 1, or word/reserved with lsb != 0. Pulse `misalign_err_o`, no write, stay in IDLE.
  - Aligned load: latch rd, we, size, unsigned and lsb; clear the timeout counter; go to WAIT_LOAD.
- **WAIT_LOAD:**
  - `ex_ready_o` = 0 and the counter increments each cycle.
  - On `dmem_rvalid_i` with `dmem_err_i` = 0:
    - Byte: select byte lane lsb, i.e. bits [8*lsb+7 : 8*lsb].
    - Half: select bits [16*lsb[1]+15 : 16*lsb[1]].
    - Word: pass the full word.
    - Extend to 32 bits per the unsigned flag.
    - Register the write (suppressed if rd = 0 or we = 0) and go to IDLE.
  - On `dmem_rvalid_i` with `dmem_err_i` = 1: pulse `load_err_o`, no write, go to IDLE.
  - If the counter reaches `LOAD_TIMEOUT - 1` without rvalid: pulse `load_err_o`, no write, go to IDLE.
- `dmem_rvalid_i` while in IDLE is ignored, including a late response after a timeout or reset.
- Outputs `data_valid_wb_o`, `load_err_o` and `misalign_err_o` are registered and deassert the cycle after their pulse.
- `rd_addr_wb_o` and `rd_data_wb_o` hold their last value when `data_valid_wb_o` is low.
- At most one of `data_valid_wb_o`, `load_err_o` and `misalign_err_o` is high in any cycle.

## Timing
- Reset: state = IDLE, counter = 0. `data_valid_wb_o`, `rd_addr_wb_o`, `rd_data_wb_o`, `load_err_o` and `misalign_err_o` are all 0. `ex_ready_o` = 1 in the first cycle after reset deasserts.
- Reset asserted mid-load abandons the load. No write or error is produced, and a subsequent rvalid is ignored.
- Non-load accepted in cycle N: write pulse in cycle N+1. Back-to-back non-loads give one write per cycle.
- Load accepted in cycle N, rvalid in cycle M (M ≥ N+1): write pulse and `ex_ready_o` = 1 in cycle M+1. A response arriving in cycle N itself is ignored.
- Timeout: with no rvalid, `load_err_o` pulses in cycle N+`LOAD_TIMEOUT` and `ex_ready_o` is high again in that same cycle.
- Misaligned load accepted in cycle N: `misalign_err_o` pulses in cycle N+1, and the next instruction can be accepted in cycle N+1.
- `ex_valid_i` while `ex_ready_o` = 0: not accepted; the upstream stage must hold its inputs.

## Test plan
- Reset, then ADD with rd = 5 and ALU result 0x0000_1234 → cycle+1: `data_valid_wb_o` = 1, `rd_addr_wb_o` = 5, `rd_data_wb_o` = 0x0000_1234; cycle+2: `data_valid_wb_o` = 0.
- LB signed, lsb = 3, rdata 0x80FF_FF00, rvalid 3 cycles after accept → `rd_data_wb_o` = 0xFFFF_FF80. Also LBU with the same stimulus → 0x0000_0080. `ex_ready_o` is low for exactly 3 cycles.
- LH signed, lsb = 2, rdata 0x7FFF_8001 → 0x0000_7FFF. LH with lsb = 1 → `misalign_err_o` pulse, no write, no wait.
- Load to rd = 0 with a valid response → `data_valid_wb_o` stays 0. Load with `dmem_err_i` = 1 → one `load_err_o` pulse, no write.
- `LOAD_TIMEOUT` = 4, load with no response → `load_err_o` pulse 4 cycles after accept. A late rvalid with 0xDEAD_BEEF produces no write.
- Assert `rst_i` during WAIT_LOAD, then rvalid → no write, all outputs 0, `ex_ready_o` = 1. Then an immediate non-load is written normally.
